// File: rtl/pps_sup_pkg.sv
// Shared types and helpers for the PPS supervisor.
package pps_sup_pkg;

    typedef enum logic [1:0] {
        ST_ACQ    = 2'd0,
        ST_LOCKED = 2'd1,
        ST_HOLD   = 2'd2,
        ST_FAULT  = 2'd3
    } pps_state_e;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/pps_edge_sync.sv
// Two-flop synchronizer for the raw PPS pin followed by a registered
// rising-edge detector; edge_o is a single-cycle pulse.
module pps_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic edge_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;
    logic edge_q;

    // Synchronize, remember previous level and register the rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            edge_q <= sync_q & ~prev_q;
        end
    end

    assign edge_o = edge_q;

endmodule

// File: rtl/pps_supervisor.sv
// PPS qualifier: measures the PPS period, locks after LOCK_CNT in-window
// periods, rejects early pulses and runs synthetic seconds in holdover.
module pps_supervisor
    import pps_sup_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 100_000_000,
    parameter int unsigned TOL      = 1000,
    parameter int unsigned LOCK_CNT = 3,
    parameter int unsigned HOLD_MAX = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pps_in,
    input  logic        clr_stat,
    output logic        sec_out,
    output logic [1:0]  state,
    output logic        locked,
    output logic        holdover,
    output logic [31:0] period,
    output logic [15:0] glitch_cnt,
    output logic [15:0] hold_cnt
);

    localparam logic [31:0] WIN_LO = 32'(CLK_FREQ - TOL - 1);
    localparam logic [31:0] WIN_HI = 32'(CLK_FREQ + TOL - 1);
    // Reload after a synthetic second: TOL (not TOL-1) so that successive
    // synthetic strobes land exactly CLK_FREQ cycles apart.
    localparam logic [31:0] RELOAD = 32'(TOL);
    localparam logic [15:0] LOCK_N = 16'(LOCK_CNT);
    localparam logic [15:0] HOLD_N = 16'(HOLD_MAX);

    pps_state_e  state_q, state_d;
    logic [31:0] per_q, per_d;
    logic [31:0] period_q, period_d;
    logic [15:0] good_q, good_d;
    logic [15:0] glitch_q, glitch_d;
    logic [15:0] hold_q, hold_d;
    logic        sec_q, sec_d;

    logic        pps_edge;
    logic        inwin;
    logic        timeout;
    logic        glitch_ev;
    logic [15:0] good_inc;

    pps_edge_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .d_i    (pps_in),
        .edge_o (pps_edge)
    );

    assign inwin    = (per_q >= WIN_LO) && (per_q <= WIN_HI);
    assign timeout  = (per_q == WIN_HI);
    assign good_inc = good_q + 16'd1;

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_ACQ;
            per_q    <= '0;
            period_q <= '0;
            good_q   <= '0;
            glitch_q <= '0;
            hold_q   <= '0;
            sec_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            per_q    <= per_d;
            period_q <= period_d;
            good_q   <= good_d;
            glitch_q <= glitch_d;
            hold_q   <= hold_d;
            sec_q    <= sec_d;
        end
    end

    // Next-state, strobe and counter updates for each supervisor state.
    always_comb begin
        state_d   = state_q;
        per_d     = sat_inc32(per_q);
        period_d  = period_q;
        good_d    = good_q;
        glitch_d  = glitch_q;
        hold_d    = hold_q;
        sec_d     = 1'b0;
        glitch_ev = 1'b0;

        if (pps_edge) begin
            period_d = sat_inc32(per_q);
        end

        unique case (state_q)
            ST_ACQ: begin
                if (pps_edge) begin
                    per_d = '0;
                    if (!inwin) begin
                        good_d = '0;
                    end else if (good_inc == LOCK_N) begin
                        good_d  = '0;
                        state_d = ST_LOCKED;
                    end else begin
                        good_d = good_inc;
                    end
                end
            end
            ST_LOCKED: begin
                if (pps_edge) begin
                    if (inwin) begin
                        sec_d = 1'b1;
                        per_d = '0;
                    end else begin
                        glitch_ev = 1'b1;
                    end
                end else if (timeout) begin
                    sec_d   = 1'b1;
                    per_d   = RELOAD;
                    hold_d  = 16'd1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (pps_edge) begin
                    if (inwin) begin
                        sec_d   = 1'b1;
                        per_d   = '0;
                        hold_d  = '0;
                        state_d = ST_LOCKED;
                    end else begin
                        glitch_ev = 1'b1;
                    end
                end else if (timeout) begin
                    if (hold_q >= HOLD_N) begin
                        state_d = ST_FAULT;
                    end else begin
                        sec_d  = 1'b1;
                        per_d  = RELOAD;
                        hold_d = sat_inc16(hold_q);
                    end
                end
            end
            ST_FAULT: begin
                if (pps_edge) begin
                    per_d   = '0;
                    good_d  = '0;
                    hold_d  = '0;
                    state_d = ST_ACQ;
                end
            end
            default: begin
                state_d = ST_ACQ;
            end
        endcase

        if (clr_stat) begin
            glitch_d = glitch_ev ? 16'd1 : '0;
        end else if (glitch_ev) begin
            glitch_d = sat_inc16(glitch_q);
        end
    end

    assign sec_out    = sec_q;
    assign state      = state_q;
    assign locked     = (state_q == ST_LOCKED);
    assign holdover   = (state_q == ST_HOLD);
    assign period     = period_q;
    assign glitch_cnt = glitch_q;
    assign hold_cnt   = hold_q;

endmodule

// File: tb/tb_pps_supervisor.sv
// Self-checking bench for pps_supervisor with a timestamp-based reference
// model plus directed scenarios carrying hand-computed expectations.
`timescale 1ns/1ps
module tb_pps_supervisor;

    localparam int CF    = 100;
    localparam int TOL   = 5;
    localparam int LOCKN = 3;
    localparam int HOLDM = 4;

    localparam int M_ACQ    = 0;
    localparam int M_LOCKED = 1;
    localparam int M_HOLD   = 2;
    localparam int M_FAULT  = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        pps_in;
    logic        clr_stat;
    logic        sec_out;
    logic [1:0]  state;
    logic        locked;
    logic        holdover;
    logic [31:0] period;
    logic [15:0] glitch_cnt;
    logic [15:0] hold_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pps_supervisor #(
        .CLK_FREQ (CF),
        .TOL      (TOL),
        .LOCK_CNT (LOCKN),
        .HOLD_MAX (HOLDM)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pps_in     (pps_in),
        .clr_stat   (clr_stat),
        .sec_out    (sec_out),
        .state      (state),
        .locked     (locked),
        .holdover   (holdover),
        .period     (period),
        .glitch_cnt (glitch_cnt),
        .hold_cnt   (hold_cnt)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Time is counted in clk edges; "anchor" is the edge at which the current
    // second began (a real accepted edge, or TOL before a synthetic second).
    int     m_state;
    longint m_now    = 0;
    longint m_anchor = 0;
    int     m_good;
    int     m_glitch;
    int     m_hold;
    longint m_period;
    bit     m_sec;
    bit     m_valid  = 0;
    bit     hist[$];

    always @(posedge clk) begin
        longint el;
        bit     ev, win, gl;
        m_now++;
        if (rst) begin
            m_state  = M_ACQ;
            m_anchor = m_now;
            m_good   = 0;
            m_glitch = 0;
            m_hold   = 0;
            m_period = 0;
            m_sec    = 0;
            hist     = '{0, 0, 0, 0, 0};
            m_valid  = 1;
        end else if (m_valid) begin
            hist.push_front(pps_in);
            void'(hist.pop_back());
            // A pin rise seen at edge k becomes an event at edge k+3.
            ev    = hist[3] && !hist[4];
            el    = m_now - m_anchor;
            win   = (el >= CF - TOL) && (el <= CF + TOL);
            gl    = 0;
            m_sec = 0;
            if (ev) m_period = el;
            case (m_state)
                M_ACQ: if (ev) begin
                    m_anchor = m_now;
                    m_good   = win ? m_good + 1 : 0;
                    if (m_good == LOCKN) begin
                        m_state = M_LOCKED;
                        m_good  = 0;
                    end
                end
                M_LOCKED: begin
                    if (ev) begin
                        if (win) begin m_sec = 1; m_anchor = m_now; end
                        else gl = 1;
                    end else if (el == CF + TOL) begin
                        m_sec    = 1;
                        m_anchor = m_now - TOL;
                        m_hold   = 1;
                        m_state  = M_HOLD;
                    end
                end
                M_HOLD: begin
                    if (ev) begin
                        if (win) begin
                            m_sec = 1; m_anchor = m_now; m_hold = 0; m_state = M_LOCKED;
                        end else gl = 1;
                    end else if (el == CF + TOL) begin
                        if (m_hold >= HOLDM) m_state = M_FAULT;
                        else begin
                            m_sec = 1; m_anchor = m_now - TOL; m_hold++;
                        end
                    end
                end
                default: if (ev) begin
                    m_state = M_ACQ; m_anchor = m_now; m_good = 0; m_hold = 0;
                end
            endcase
            if (clr_stat) m_glitch = gl ? 1 : 0;
            else if (gl && m_glitch < 65535) m_glitch++;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("cyc_sec_out", sec_out, m_sec);
            check("cyc_state", state, m_state);
            check("cyc_locked", locked, m_state == M_LOCKED);
            check("cyc_holdover", holdover, m_state == M_HOLD);
            check("cyc_period", period, m_period);
            check("cyc_glitch_cnt", glitch_cnt, m_glitch);
            check("cyc_hold_cnt", hold_cnt, m_hold);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    // Raise pps, check the strobe 4 edges later, then pad to 'gap' edges.
    task automatic pulse_check(input string tag, input int gap, input bit exp_sec, input int exp_state);
        pps_in = 1'b1;
        tick(3);
        check({tag, "_pre"}, sec_out, 0);
        tick(1);
        check({tag, "_sec"}, sec_out, exp_sec);
        check({tag, "_state"}, state, exp_state);
        tick(1);
        pps_in = 1'b0;
        tick(gap - 5);
    endtask

    task automatic wait_strobe(input string tag, input int budget, output int waited);
        bit found = 0;
        waited = 0;
        while (!found && waited < budget) begin
            tick(1);
            waited++;
            if (sec_out) found = 1;
        end
        check({tag, "_found"}, found, 1);
    endtask

    int exp_t[4] = '{105, 205, 305, 405};

    initial begin
        int rel, k, w;
        rst = 1'b1; pps_in = 1'b0; clr_stat = 1'b0;
        tick(3);
        check("rst_state", state, 0);
        check("rst_sec", sec_out, 0);
        check("rst_locked", locked, 0);
        check("rst_period", period, 0);
        check("rst_glitch", glitch_cnt, 0);
        check("rst_hold", hold_cnt, 0);
        rst = 1'b0;
        tick(20);

        // 1: acquisition and lock
        for (int i = 0; i < 5; i++)
            pulse_check($sformatf("t1_e%0d", i), 100, i == 4, (i >= 3) ? 1 : 0);
        check("t1_period", period, 100);
        check("t1_locked", locked, 1);

        // 2: loss of PPS -> holdover -> fault
        rel = 96; k = 0;
        for (int c = 0; c < 520; c++) begin
            tick(1);
            rel++;
            if (sec_out) begin
                if (k < 4) begin
                    check("t2_synth_time", rel, exp_t[k]);
                    check("t2_hold_cnt", hold_cnt, k + 1);
                    check("t2_holdover", holdover, 1);
                end
                k++;
            end
            if (rel == 505) break;
        end
        check("t2_rel_reached", rel, 505);
        check("t2_fault_state", state, 3);
        check("t2_fault_nostrobe", sec_out, 0);
        check("t2_synth_count", k, 4);

        // relock from FAULT
        for (int i = 0; i < 4; i++)
            pulse_check($sformatf("t3_relock%0d", i), 100, 0, (i == 3) ? 1 : 0);

        // 3: holdover recovered by an edge 98 cycles after a synthetic strobe
        wait_strobe("t3_synth", 30, w);
        check("t3_synth_delay", w, 9);
        check("t3_synth_hold", hold_cnt, 1);
        tick(94);
        pps_in = 1'b1;
        tick(4);
        check("t3_sec", sec_out, 1);
        check("t3_state", state, 1);
        check("t3_hold", hold_cnt, 0);
        check("t3_period", period, 103);
        tick(1);
        pps_in = 1'b0;

        // 4: early glitch 40 cycles after an edge, then clr_stat
        tick(35);
        pps_in = 1'b1;
        tick(4);
        check("t4_glitch_nosec", sec_out, 0);
        check("t4_glitch_cnt", glitch_cnt, 1);
        check("t4_glitch_period", period, 40);
        tick(1);
        pps_in = 1'b0;
        tick(55);
        pps_in = 1'b1;
        tick(4);
        check("t4_next_sec", sec_out, 1);
        check("t4_next_period", period, 100);
        tick(1);
        pps_in = 1'b0;
        clr_stat = 1'b1;
        tick(1);
        clr_stat = 1'b0;
        check("t4_clr", glitch_cnt, 0);

        // 5: window boundaries
        tick(89);
        pps_in = 1'b1;
        tick(4);
        check("t5_p95_sec", sec_out, 1);
        check("t5_p95_period", period, 95);
        tick(1);
        pps_in = 1'b0;
        tick(89);
        pps_in = 1'b1;
        tick(3);
        clr_stat = 1'b1;
        tick(1);
        clr_stat = 1'b0;
        check("t5_p94_nosec", sec_out, 0);
        check("t5_p94_period", period, 94);
        check("t5_clr_with_glitch", glitch_cnt, 1);
        tick(1);
        pps_in = 1'b0;
        tick(6);
        pps_in = 1'b1;
        tick(4);
        check("t5_p105_sec", sec_out, 1);
        check("t5_p105_period", period, 105);
        check("t5_p105_state", state, 1);
        check("t5_p105_hold", hold_cnt, 0);
        tick(1);
        pps_in = 1'b0;
        check("t5_p105_single", sec_out, 0);

        // 6: reset in holdover, then relock
        wait_strobe("t6_synth", 120, w);
        check("t6_in_holdover", holdover, 1);
        tick(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("t6_state", state, 0);
        check("t6_sec", sec_out, 0);
        check("t6_holdover", holdover, 0);
        check("t6_period", period, 0);
        check("t6_glitch", glitch_cnt, 0);
        check("t6_hold", hold_cnt, 0);
        tick(20);
        for (int i = 0; i < 4; i++)
            pulse_check($sformatf("t6_relock%0d", i), 100, 0, (i == 3) ? 1 : 0);
        check("t6_locked", locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
